mem_access_unit: RTL and testbench

Parametrised memory-stage access unit that replaces the single-cycle MEM logic with a handshaked data-memory port and a multi-channel MMIO output bank. It accepts one load/store per transaction from the EX/MEM register and produces byte enables and lane-replicated store data. It drives a grant/response data-memory interface, aligns and sign-extends load data, and stalls the pipeline through `req_ready` until the access completes.

---
 rtl/mem_access_unit.sv | 208 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: handshaked dmem port plus an MMIO output bank.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned accesses complete without touching memory).
module mem_access_unit #(
    parameter int               XLEN      = 32,
    parameter int               NUM_CH    = 4,
    parameter int               CH_WIDTH  = 4,
    parameter logic [XLEN-1:0]  MMIO_BASE = 32'hFFFF_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [XLEN-1:0]            addr,
    input  logic [XLEN-1:0]            wdata,
    input  logic                       mem_read_en,
    input  logic                       mem_write_en,
    input  logic [2:0]                 funct3,
    output logic                       resp_valid,
    output logic [XLEN-1:0]            rdata,
    output logic                       misalign,
    output logic                       dmem_req,
    output logic                       dmem_we,
    output logic [XLEN-1:0]            dmem_addr,
    output logic [3:0]                 dmem_be,
    output logic [XLEN-1:0]            dmem_wdata,
    input  logic                       dmem_gnt,
    input  logic                       dmem_rvalid,
    input  logic [XLEN-1:0]            dmem_rdata,
    output logic [NUM_CH*CH_WIDTH-1:0] ch_out
);

    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [XLEN-3:0] MMIO_WBASE = MMIO_BASE[XLEN-1:2];

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic            accept;
    logic            is_byte, is_half, is_word;
    logic            mis_in;
    logic            trap_in;
    logic            mmio_hit;
    logic [IW-1:0]   mmio_idx;
    logic [3:0]      be_in;
    logic [XLEN-1:0] wdata_in;
    logic [XLEN-1:0] fmt;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;

    logic            we_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;

    logic [CH_WIDTH-1:0] ch_q [NUM_CH];

    assign accept  = req_valid && (state_q == IDLE) && (mem_read_en || mem_write_en);
    assign is_byte = (funct3[1:0] == 2'b00);
    assign is_half = (funct3[1:0] == 2'b01);
    assign is_word = funct3[1];
    assign mis_in  = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));

`ifdef MISALIGN_TRAP_EN
    logic misalign_q;

    assign trap_in  = mis_in;
    assign misalign = misalign_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (accept) begin
            misalign_q <= trap_in;
        end
    end
`else
    assign trap_in  = 1'b0;
    assign misalign = 1'b0;
`endif

    // Only the first NUM_CH words of the window are decoded; the rest is plain memory.
    always_comb begin
        mmio_hit = 1'b0;
        mmio_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr[XLEN-1:2] == MMIO_WBASE + (XLEN-2)'(i)) begin
                mmio_hit = 1'b1;
                mmio_idx = IW'(i);
            end
        end
    end

    always_comb begin
        unique case (funct3[1:0])
            2'b00:   be_in = 4'b0001 << addr[1:0];
            2'b01:   be_in = addr[1] ? 4'b1100 : 4'b0011;
            default: be_in = 4'b1111;
        endcase
    end

    always_comb begin
        unique case (funct3[1:0])
            2'b00:   wdata_in = {4{wdata[7:0]}};
            2'b01:   wdata_in = {2{wdata[15:0]}};
            default: wdata_in = wdata;
        endcase
    end

    always_comb begin
        lane_b = dmem_rdata[{off_q, 3'b000} +: 8];
        lane_h = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        unique case (f3_q[1:0])
            2'b00: begin
                fmt = f3_q[2] ? {{(XLEN-8){1'b0}}, lane_b}
                              : {{(XLEN-8){lane_b[7]}}, lane_b};
            end
            2'b01: begin
                fmt = f3_q[2] ? {{(XLEN-16){1'b0}}, lane_h}
                              : {{(XLEN-16){lane_h[15]}}, lane_h};
            end
            default: fmt = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (mmio_hit || trap_in) ? RESP : REQ;
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    state_d = we_q ? RESP : WAIT_R;
                end
            end
            WAIT_R: begin
                if (dmem_rvalid) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        dmem_req   = (state_q == REQ);
        dmem_we    = (state_q == REQ) && we_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q       <= 1'b0;
            f3_q       <= 3'b000;
            off_q      <= 2'b00;
            rdata      <= '0;
            dmem_addr  <= '0;
            dmem_be    <= 4'b0000;
            dmem_wdata <= '0;
        end else if (accept) begin
            we_q  <= mem_write_en;
            f3_q  <= funct3;
            off_q <= addr[1:0];
            if (!mmio_hit && !trap_in) begin
                dmem_addr  <= {addr[XLEN-1:2], 2'b00};
                dmem_be    <= be_in;
                dmem_wdata <= wdata_in;
            end
            if (mmio_hit && !trap_in && !mem_write_en) begin
                rdata <= XLEN'(ch_q[mmio_idx]);
            end else begin
                rdata <= '0;
            end
        end else if ((state_q == WAIT_R) && dmem_rvalid) begin
            rdata <= fmt;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        always_ff @(posedge clk) begin
            if (rst) begin
                ch_q[g] <= '0;
            end else if (accept && mmio_hit && !trap_in && mem_write_en
                         && (mmio_idx == IW'(g))) begin
                ch_q[g] <= wdata[CH_WIDTH-1:0];
            end
        end
        assign ch_out[g*CH_WIDTH +: CH_WIDTH] = ch_q[g];
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against an arithmetic reference model.
// Expectations follow MISALIGN_TRAP_EN when the macro is defined for the build.
module tb_mem_access_unit;

    localparam int          NUM_CH   = 4;
    localparam int          CH_WIDTH = 4;
    localparam logic [31:0] BASE     = 32'hFFFF_0000;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [2:0]  funct3;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        misalign;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [NUM_CH*CH_WIDTH-1:0] ch_out;

    mem_access_unit #(
        .XLEN(32), .NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .MMIO_BASE(BASE)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .addr(addr), .wdata(wdata),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .funct3(funct3),
        .resp_valid(resp_valid), .rdata(rdata), .misalign(misalign),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .ch_out(ch_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [CH_WIDTH-1:0] ch_m [NUM_CH];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NUM_CH*CH_WIDTH-1:0] ch_packed();
        logic [NUM_CH*CH_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CH; i++) v[i*CH_WIDTH +: CH_WIDTH] = ch_m[i];
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input logic [31:0] a, input logic [2:0] f);
        int off = int'(a % 4);
        if (f % 4 == 0) return 4'(1 << off);
        if (f % 4 == 1) return (off >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wd(input logic [31:0] w, input logic [2:0] f);
        if (f % 4 == 0) return (w & 32'hFF) * 32'h0101_0101;
        if (f % 4 == 1) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] ref_ld(input logic [31:0] w, input logic [31:0] a,
                                           input logic [2:0] f);
        logic [31:0] v;
        int off = int'(a % 4);
        if (f % 4 == 0) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (f < 4 && v >= 128) v = v + 32'hFFFF_FF00;
            return v;
        end
        if (f % 4 == 1) begin
            v = (w >> (16 * (off / 2))) & 32'hFFFF;
            if (f < 4 && v >= 32768) v = v + 32'hFFFF_0000;
            return v;
        end
        return w;
    endfunction

    function automatic bit ref_mis(input logic [31:0] a, input logic [2:0] f);
        return (f % 4 == 1 && a % 2 == 1) || (f % 4 >= 2 && a % 4 != 0);
    endfunction

    function automatic int ref_ch(input logic [31:0] a);
        logic [31:0] k;
        if (a < BASE) return -1;
        k = (a - BASE) / 4;
        if (k < NUM_CH) return int'(k);
        return -1;
    endfunction

    // Called at a negedge with the unit idle; returns at the negedge after resp_valid.
    task automatic access(input logic [31:0] a, input logic [31:0] wd, input bit wr,
                          input logic [2:0] f, input int gd, input int rd,
                          input logic [31:0] word);
        int ci;
        bit trapped, mem, done;
        int lat, req_cnt, since_gnt;
        logic [31:0] exp_rd;
        ci      = ref_ch(a);
        trapped = TRAP && ref_mis(a, f);
        mem     = !trapped && ci < 0;
        lat     = !mem ? 1 : (wr ? 2 + gd : 3 + gd + rd);
        if (trapped) exp_rd = 32'h0;
        else if (ci >= 0) exp_rd = 32'(ch_m[ci]);
        else exp_rd = ref_ld(word, a, f);
        chk("ready_idle", req_ready, 1);
        req_valid    = 1'b1;
        addr         = a;
        wdata        = wd;
        mem_read_en  = !wr;
        mem_write_en = wr;
        funct3       = f;
        @(posedge clk);
        if (!trapped && ci >= 0 && wr) ch_m[ci] = wd[CH_WIDTH-1:0];
        done      = 1'b0;
        req_cnt   = 0;
        since_gnt = 0;
        for (int c = 1; c <= 60 && !done; c++) begin
            @(negedge clk);
            req_valid   = 1'b0;
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
            dmem_rdata  = $urandom;
            if (resp_valid) begin
                done = 1'b1;
                chk("latency", c, lat);
                chk("misalign", misalign, trapped);
                if (!wr) chk("rdata", rdata, exp_rd);
            end else begin
                chk("ready_busy", req_ready, 0);
                if (dmem_req) begin
                    if (!mem) begin
                        chk("no_dmem_req", dmem_req, 0);
                    end else begin
                        chk("dmem_addr", dmem_addr, a & 32'hFFFF_FFFC);
                        chk("dmem_be", dmem_be, ref_be(a, f));
                        chk("dmem_we", dmem_we, wr);
                        if (wr) chk("dmem_wdata", dmem_wdata, ref_wd(wd, f));
                        if (req_cnt == gd) dmem_gnt = 1'b1;
                        else if ($urandom_range(0, 2) == 0) dmem_rvalid = 1'b1;
                        req_cnt++;
                    end
                end else if (req_cnt > gd) begin
                    if (since_gnt == rd) begin
                        dmem_rvalid = 1'b1;
                        dmem_rdata  = word;
                    end else begin
                        dmem_gnt = 1'($urandom_range(0, 1));
                    end
                    since_gnt++;
                end
            end
        end
        if (!done) chk("resp_timeout", 0, 1);
        chk("ch_out", ch_out, ch_packed());
        @(negedge clk);
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        chk("resp_pulse", resp_valid, 0);
    endtask

    task automatic reset_in_wait_r();
        chk("rw_ready", req_ready, 1);
        req_valid    = 1'b1;
        addr         = 32'h0000_0300;
        mem_read_en  = 1'b1;
        mem_write_en = 1'b0;
        funct3       = 3'b010;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rw_req", dmem_req, 1);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        chk("rw_wait", dmem_req, 0);
        chk("rw_busy", req_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NUM_CH; i++) ch_m[i] = '0;
        chk("rw_dmem_req", dmem_req, 0);
        chk("rw_resp", resp_valid, 0);
        chk("rw_idle", req_ready, 1);
        chk("rw_ch_out", ch_out, ch_packed());
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk("rw_late_rv", resp_valid, 0);
        @(negedge clk);
        chk("rw_late_rv2", resp_valid, 0);
        chk("rw_rdata", rdata, 0);
    endtask

    logic [2:0] lf [5];

    initial begin
        lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < NUM_CH; i++) ch_m[i] = '0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        addr         = '0;
        wdata        = '0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        funct3       = '0;
        dmem_gnt     = 1'b0;
        dmem_rvalid  = 1'b0;
        dmem_rdata   = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_resp", resp_valid, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_dmem_we", dmem_we, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_dmem_addr", dmem_addr, 0);
        chk("rst_dmem_be", dmem_be, 0);
        chk("rst_dmem_wdata", dmem_wdata, 0);
        chk("rst_ch_out", ch_out, 0);
        rst = 1'b0;
        @(negedge clk);

        access(32'h0000_0103, 32'h0000_00AB, 1'b1, 3'b000, 0, 0, 32'h0);
        access(32'h0000_0102, 32'h0, 1'b0, 3'b000, 0, 2, 32'h1280_3344);
        access(32'h0000_0102, 32'h0, 1'b0, 3'b100, 0, 2, 32'h1280_3344);
        access(BASE + 32'd8, 32'h0000_0005, 1'b1, 3'b010, 0, 0, 32'h0);
        access(BASE + 32'd8, 32'h0, 1'b0, 3'b010, 0, 0, 32'h0);
        access(BASE + 32'd4, 32'h0000_000C, 1'b1, 3'b000, 0, 0, 32'h0);
        access(BASE + 32'd16, 32'h0000_0077, 1'b1, 3'b010, 1, 0, 32'h0);
        access(32'h0000_0201, 32'h0, 1'b0, 3'b001, 0, 1, 32'h8765_4321);
        access(32'h0000_0206, 32'h0, 1'b0, 3'b001, 0, 0, 32'h8765_4321);
        access(32'h0000_0400, 32'h0, 1'b0, 3'b010, 5, 1, 32'hCAFE_F00D);
        access(32'h0000_0402, 32'h0000_BEEF, 1'b1, 3'b001, 2, 0, 32'h0);
        reset_in_wait_r();

        for (int n = 0; n < 200; n++) begin
            bit          wr;
            logic [2:0]  f;
            logic [31:0] a;
            int          r;
            wr = 1'($urandom_range(0, 1));
            f  = wr ? lf[$urandom_range(0, 2)] : lf[$urandom_range(0, 4)];
            r  = $urandom_range(0, 3);
            if (r < 2) a = 32'($urandom_range(0, 32'hFFF));
            else if (r == 2) a = BASE + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
            else a = $urandom;
            access(a, $urandom, wr, f, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
